pet_mem_arbiter: RTL and testbench
==================================

Name: pet_mem_arbiter

Overview:
- Sequences the single shared SDRAM byte port between two requesters: the ROM/TAP download stream (byte writes) and the tape player (byte reads).
- Sits between the downloader/tape logic and the sram controller. It replaces the ad-hoc address/we/rd muxing with one buffered, prioritised, timeout-guarded access scheduler.

Parameters:
- AW, 25: address width, in bits.
- TIMEOUT, 1024: maximum number of cycles an access may wait for mem_ready before it is aborted.
- FILL, 8'hFF: data value returned on a read that timed out.

Ports:
- clk  in  1  system clock, 112 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  a download is in progress.
- dl_wr  in  1  single-cycle write strobe from the downloader.
- dl_addr  in  AW  write address.
- dl_data  in  8  write data.
- dl_busy  out  1  the write buffer is occupied.
- rd_req  in  1  single-cycle read request from the tape player.
- rd_addr  in  AW  read address.
- rd_data  out  8  read data; held between reads.
- rd_valid  out  1  single-cycle pulse: rd_data has been updated.
- mem_addr  out  AW  address to sram.
- mem_din  out  8  write data to sram.
- mem_we  out  1  write request, level.
- mem_rd  out  1  read request, level.
- mem_dout  in  8  read data from sram.
- mem_ready  in  1  access complete.
- err_timeout  out  1  sticky: at least one access was aborted.
- err_overrun  out  1  sticky: a write strobe was dropped.

Behaviour:
- Reset values: all outputs 0 except rd_data = 8'h00. FSM = IDLE. Both pending flags clear.
- Reset asserted mid-access: mem_we/mem_rd drop immediately (asynchronous). The in-flight access is discarded and no rd_valid is issued.
- Write buffer (one entry):
  - dl_wr with the buffer empty: latch addr/data and set wpend. dl_busy = wpend.
  - dl_wr with the buffer full: the strobe is dropped, the buffer is unchanged, and err_overrun is set.
- Read slot (one entry):
  - rd_req latches rd_addr and sets rpend.
  - A new rd_req while rpend is set and not yet issued replaces the address (latest wins).
  - A rd_req arriving during an issued read is latched as the next pending read.
- FSM states: IDLE, WRITE, READ, GAP.
- IDLE:
  - If wpend, go to WRITE: mem_we=1, mem_addr/mem_din from the buffer.
  - Else if rpend and !dl_active, go to READ: mem_rd=1, mem_addr = read address.
  - Writes always win. Reads are held off entirely while dl_active=1.
- WRITE/READ:
  - The request is held at a constant level until mem_ready is sampled high. The cycle counter starts at 0 on entry.
  - On mem_ready in WRITE: clear wpend and go to GAP.
  - On mem_ready in READ: rd_data <= mem_dout, pulse rd_valid next cycle, clear rpend (unless replaced by a new request), go to GAP.
  - Counter reaches TIMEOUT-1 without mem_ready: abort.
    - Deassert the request, set err_timeout, go to GAP.
    - A write is cleared from the buffer.
    - A read returns rd_data=FILL with rd_valid.
- GAP: mem_we and mem_rd are both low for exactly one cycle, then IDLE.
- Latency, idle memory:
  - rd_req at cycle 0 → mem_rd high at cycle 2.
  - mem_ready at cycle k → rd_valid at cycle k+1.
  - Back-to-back accesses are separated by ≥2 idle cycles (GAP + IDLE).
- mem_addr/mem_din may hold their last value while idle. mem_we and mem_rd are never high together.
- Simultaneous dl_wr and rd_req: both are latched. The write is issued first and the read is issued after GAP, provided dl_active=0.
- dl_active falling with rpend set: the read issues on the next IDLE evaluation.
- err_* flags are cleared only by reset.

Decomposition:
- Shared package pet_mem_pkg holds:
  - the FSM state enum {IDLE, WRITE, READ, GAP};
  - the default AW;
  - the FILL constant.
- No sub-module is needed. The timeout counter is inline, width $clog2(TIMEOUT).

Test Plan:
- dl_active=1; 3 writes spaced 8 cycles apart to 0x10..0x12 (data A1..A3); mem_ready 3 cycles after each request → three mem_we bursts with the correct addr/data; err_overrun=0.
- Two dl_wr strobes on consecutive cycles while mem_ready is held low → the second is dropped, err_overrun=1, only the first address reaches mem_addr.
- dl_active=0; rd_req addr 0x1234; mem_ready at cycle 5 with mem_dout=0x5A → rd_valid at cycle 6, rd_data=0x5A.
- Same-cycle dl_wr(0x20, 0x77) and rd_req(0x30) with dl_active=0 → WRITE, then GAP, then READ of 0x30. The read is held pending while dl_active=1 and issues after it falls.
- mem_ready never asserted on a read → abort after 1024 cycles; rd_valid with rd_data=0xFF; err_timeout=1; the next read proceeds normally.
- reset_n pulsed low during READ → mem_rd drops in the same cycle, no rd_valid, all flags 0.

Source files
------------

// File: rtl/pet_mem_pkg.sv
// Shared types and constants for the PET shared-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pet_mem_pkg;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      GAP   = 2'd3
   } state_t;

   // Default SDRAM byte address width
   localparam int PET_AW = 25;

   // Byte returned to the tape player when a read is abandoned
   localparam logic [7:0] PET_FILL = 8'hFF;

endpackage

// File: rtl/pet_mem_arbiter.sv
// Schedules the shared SDRAM byte port between download writes and tape reads.
// Latency: request at cycle 0 -> mem_we/mem_rd at cycle 2; mem_ready at k -> rd_valid at k+1.
// Backpressure: one-entry write buffer (dl_busy, extra strobes dropped); one-entry read slot, latest wins.
module pet_mem_arbiter
   import pet_mem_pkg::*;
#(
   parameter int         AW      = PET_AW,
   parameter int         TIMEOUT = 1024,
   parameter logic [7:0] FILL    = PET_FILL
) (
   input  logic          clk,
   input  logic          reset_n,
   // downloader write side
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [AW-1:0] dl_addr,
   input  logic [7:0]    dl_data,
   output logic          dl_busy,
   // tape player read side
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   // sram controller side
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_we,
   output logic          mem_rd,
   input  logic [7:0]    mem_dout,
   input  logic          mem_ready,
   // sticky error flags
   output logic          err_timeout,
   output logic          err_overrun
);

   // Counter just wide enough to reach TIMEOUT-1
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] cnt;

   // write buffer
   logic          wpend;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;

   // read slot; r_again marks a request that arrived after the current read was issued
   logic          rpend;
   logic          r_again;
   logic [AW-1:0] raddr;

   logic tmo;
   logic wr_fin;
   logic rd_fin;
   logic rd_issue;

   // Access completion (ready or abort) and read issue decisions
   always_comb begin
      tmo      = (cnt == CNT_LAST);
      wr_fin   = (state == WRITE) && (mem_ready || tmo);
      rd_fin   = (state == READ)  && (mem_ready || tmo);
      rd_issue = (state == IDLE) && !wpend && rpend && !dl_active;
   end

   assign dl_busy = wpend;

   // Write buffer: accept a strobe only when empty, otherwise flag the drop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wpend       <= 1'b0;
         waddr       <= '0;
         wdata       <= 8'h00;
         err_overrun <= 1'b0;
      end else begin
         if (wr_fin) begin
            wpend <= 1'b0;
         end
         if (dl_wr) begin
            if (wpend) begin
               err_overrun <= 1'b1;
            end else begin
               wpend <= 1'b1;
               waddr <= dl_addr;
               wdata <= dl_data;
            end
         end
      end
   end

   // Read slot: newest address always wins; a request seen once the read has
   // been issued survives the completion of that read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpend   <= 1'b0;
         r_again <= 1'b0;
         raddr   <= '0;
      end else begin
         if (rd_fin) begin
            rpend   <= r_again;
            r_again <= 1'b0;
         end
         if (rd_req) begin
            raddr <= rd_addr;
            rpend <= 1'b1;
            if (rd_issue || ((state == READ) && !rd_fin)) begin
               r_again <= 1'b1;
            end
         end
      end
   end

   // Access sequencer with registered memory strobes, read result and timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_addr    <= '0;
         mem_din     <= 8'h00;
         mem_we      <= 1'b0;
         mem_rd      <= 1'b0;
         rd_data     <= 8'h00;
         rd_valid    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (wpend) begin
                  state    <= WRITE;
                  mem_we   <= 1'b1;
                  mem_addr <= waddr;
                  mem_din  <= wdata;
               end else if (rd_issue) begin
                  state    <= READ;
                  mem_rd   <= 1'b1;
                  mem_addr <= raddr;
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  mem_we <= 1'b0;
                  state  <= GAP;
               end else if (tmo) begin
                  mem_we      <= 1'b0;
                  err_timeout <= 1'b1;
                  state       <= GAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            READ: begin
               if (mem_ready) begin
                  mem_rd   <= 1'b0;
                  rd_data  <= mem_dout;
                  rd_valid <= 1'b1;
                  state    <= GAP;
               end else if (tmo) begin
                  mem_rd      <= 1'b0;
                  rd_data     <= FILL;
                  rd_valid    <= 1'b1;
                  err_timeout <= 1'b1;
                  state       <= GAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               mem_we <= 1'b0;
               mem_rd <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pet_mem_arbiter.sv
// Directed bench for pet_mem_arbiter.
// Latency: checks exact cycle positions of strobes and rd_valid.
// Backpressure: exercises buffer overrun, read hold-off and timeouts.
module tb_pet_mem_arbiter;

   localparam int AW = 25;

   logic          clk;
   logic          reset_n;
   logic          dl_active;
   logic          dl_wr;
   logic [AW-1:0] dl_addr;
   logic [7:0]    dl_data;
   logic          dl_busy;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_we;
   logic          mem_rd;
   logic [7:0]    mem_dout;
   logic          mem_ready;
   logic          err_timeout;
   logic          err_overrun;

   int n_total;
   int n_pass;
   int n_fail;

   pet_mem_arbiter #(.AW(AW), .TIMEOUT(1024), .FILL(8'hFF)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .dl_active   (dl_active),
      .dl_wr       (dl_wr),
      .dl_addr     (dl_addr),
      .dl_data     (dl_data),
      .dl_busy     (dl_busy),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_we      (mem_we),
      .mem_rd      (mem_rd),
      .mem_dout    (mem_dout),
      .mem_ready   (mem_ready),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance n clock edges, land 1 time unit after the last edge
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      n_fail  = 0;
      reset_n   = 1'b0;
      dl_active = 1'b0;
      dl_wr     = 1'b0;
      dl_addr   = '0;
      dl_data   = 8'h00;
      rd_req    = 1'b0;
      rd_addr   = '0;
      mem_dout  = 8'h00;
      mem_ready = 1'b0;

      // ---- reset state
      cyc(3);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_dl_busy", dl_busy, 0);
      chk("rst_errs", {err_timeout, err_overrun}, 2'b00);
      reset_n = 1'b1;
      cyc(2);

      // ---- three buffered writes while downloading, ready 3 cycles after request
      dl_active = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dl_wr   = 1'b1;
         dl_addr = AW'(32'h10 + i);
         dl_data = 8'hA1 + 8'(i);
         cyc(1);
         dl_wr = 1'b0;
         chk("wr_busy", dl_busy, 1);
         chk("wr_we_early", mem_we, 0);
         cyc(1);
         chk("wr_we", mem_we, 1);
         chk("wr_addr", mem_addr, 32'h10 + i);
         chk("wr_din", mem_din, 32'hA1 + i);
         cyc(3);
         chk("wr_we_held", {mem_we, mem_rd}, 2'b10);
         mem_ready = 1'b1;
         cyc(1);
         mem_ready = 1'b0;
         chk("wr_we_drop", mem_we, 0);
         chk("wr_busy_clr", dl_busy, 0);
         cyc(2);
      end
      chk("wr_no_overrun", err_overrun, 0);

      // ---- overrun: second strobe on the next cycle is dropped
      dl_wr   = 1'b1;
      dl_addr = AW'(32'h40);
      dl_data = 8'hB1;
      cyc(1);
      dl_addr = AW'(32'h41);
      dl_data = 8'hB2;
      cyc(1);
      dl_wr = 1'b0;
      chk("ovr_flag", err_overrun, 1);
      chk("ovr_we", mem_we, 1);
      chk("ovr_addr0", mem_addr, 32'h40);
      cyc(2);
      chk("ovr_addr_hold", mem_addr, 32'h40);
      chk("ovr_din_hold", mem_din, 8'hB1);
      mem_ready = 1'b1;
      cyc(1);
      mem_ready = 1'b0;
      cyc(2);
      chk("ovr_no_second", mem_we, 0);
      chk("ovr_busy", dl_busy, 0);

      // ---- plain read, ready at cycle 5
      dl_active = 1'b0;
      rd_req    = 1'b1;
      rd_addr   = AW'(32'h1234);
      cyc(1);
      rd_req = 1'b0;
      chk("rd_c1", mem_rd, 0);
      cyc(1);
      chk("rd_c2", mem_rd, 1);
      chk("rd_addr", mem_addr, 32'h1234);
      cyc(3);
      chk("rd_c5_novalid", {mem_rd, rd_valid}, 2'b10);
      mem_ready = 1'b1;
      mem_dout  = 8'h5A;
      cyc(1);
      mem_ready = 1'b0;
      mem_dout  = 8'h00;
      chk("rd_c6_valid", rd_valid, 1);
      chk("rd_c6_data", rd_data, 8'h5A);
      chk("rd_c6_rd_low", mem_rd, 0);
      cyc(1);
      chk("rd_c7_pulse", rd_valid, 0);
      chk("rd_c7_hold", rd_data, 8'h5A);

      // ---- simultaneous write and read: write first, then gap, then read
      dl_wr   = 1'b1;
      dl_addr = AW'(32'h20);
      dl_data = 8'h77;
      rd_req  = 1'b1;
      rd_addr = AW'(32'h30);
      cyc(1);
      dl_wr  = 1'b0;
      rd_req = 1'b0;
      cyc(1);
      chk("sim_we", {mem_we, mem_rd}, 2'b10);
      chk("sim_waddr", mem_addr, 32'h20);
      chk("sim_wdin", mem_din, 8'h77);
      cyc(1);
      mem_ready = 1'b1;
      cyc(1);
      mem_ready = 1'b0;
      chk("sim_gap", {mem_we, mem_rd}, 2'b00);
      cyc(1);
      chk("sim_idle", {mem_we, mem_rd}, 2'b00);
      cyc(1);
      chk("sim_rd", {mem_we, mem_rd}, 2'b01);
      chk("sim_raddr", mem_addr, 32'h30);
      mem_ready = 1'b1;
      mem_dout  = 8'h33;
      cyc(1);
      mem_ready = 1'b0;
      chk("sim_rdata", {rd_valid, rd_data}, 9'h133);

      // ---- read held off during download, latest address wins
      dl_active = 1'b1;
      rd_req    = 1'b1;
      rd_addr   = AW'(32'h31);
      cyc(1);
      rd_addr = AW'(32'h32);
      cyc(1);
      rd_req = 1'b0;
      cyc(4);
      chk("hold_no_rd", mem_rd, 0);
      dl_active = 1'b0;
      cyc(1);
      chk("hold_rd", mem_rd, 1);
      chk("hold_addr", mem_addr, 32'h32);
      mem_ready = 1'b1;
      mem_dout  = 8'h44;
      cyc(1);
      mem_ready = 1'b0;
      chk("hold_rdata", {rd_valid, rd_data}, 9'h144);
      cyc(2);
      chk("hold_single", mem_rd, 0);

      // ---- read timeout returns FILL
      rd_req  = 1'b1;
      rd_addr = AW'(32'h55);
      cyc(1);
      rd_req = 1'b0;
      cyc(1);
      chk("tmo_rd_start", mem_rd, 1);
      cyc(1023);
      chk("tmo_rd_last", {mem_rd, rd_valid, err_timeout}, 3'b100);
      cyc(1);
      chk("tmo_rd_abort", {mem_rd, rd_valid, err_timeout}, 3'b011);
      chk("tmo_rd_fill", rd_data, 8'hFF);
      cyc(2);
      rd_req  = 1'b1;
      rd_addr = AW'(32'h56);
      cyc(1);
      rd_req = 1'b0;
      cyc(1);
      chk("tmo_next_addr", {mem_rd, mem_addr}, {1'b1, 25'h56});
      mem_ready = 1'b1;
      mem_dout  = 8'h6B;
      cyc(1);
      mem_ready = 1'b0;
      chk("tmo_next_data", {rd_valid, rd_data}, 9'h16B);
      cyc(2);

      // ---- write timeout clears the buffer
      dl_wr   = 1'b1;
      dl_addr = AW'(32'h60);
      dl_data = 8'hC3;
      cyc(1);
      dl_wr = 1'b0;
      cyc(1);
      chk("tmo_wr_start", mem_we, 1);
      cyc(1023);
      chk("tmo_wr_last", {mem_we, dl_busy}, 2'b11);
      cyc(1);
      chk("tmo_wr_abort", {mem_we, dl_busy}, 2'b00);
      chk("tmo_sticky", {err_timeout, err_overrun}, 2'b11);
      cyc(2);

      // ---- asynchronous reset in the middle of a read
      rd_req  = 1'b1;
      rd_addr = AW'(32'h77);
      cyc(1);
      rd_req = 1'b0;
      cyc(2);
      chk("arst_pre", mem_rd, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_rd_drop", mem_rd, 0);
      chk("arst_flags", {err_timeout, err_overrun, dl_busy, rd_valid}, 4'b0000);
      chk("arst_rd_data", rd_data, 8'h00);
      cyc(1);
      mem_ready = 1'b1;
      mem_dout  = 8'h99;
      reset_n   = 1'b1;
      cyc(1);
      mem_ready = 1'b0;
      chk("arst_no_valid", {rd_valid, mem_rd}, 2'b00);
      cyc(3);
      chk("arst_discarded", {mem_rd, mem_we, rd_valid}, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
